// File: rtl/acc_mul_seq.sv
// Shift-and-add multiply sequencer that steers the 4-bit CPU accumulator.
// Each iteration tests the low LSB, adds the multiplicand into acc_high, then shifts {high,low} right.
module acc_mul_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       acc_low_lsb,
    input  logic       alu_carry,
    output logic       acc_in_select,
    output logic [1:0] acc_high_select,
    output logic [1:0] acc_low_select,
    output logic       acc_high_reset_p,
    output logic       fill_value,
    output logic       alu_add,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_CLR_HI,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               r_carry_q;
    logic               w_nxt_carry;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_carry = r_carry_q;
        // abort overrides everything, including a start in the same IDLE cycle
        if (abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_carry = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nxt_state = S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    w_nxt_state = S_CLR_HI;
                end
                S_CLR_HI: begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_TEST;
                end
                S_TEST: begin
                    if (acc_low_lsb) begin
                        w_nxt_state = S_ADD;
                    end else begin
                        w_nxt_carry = 1'b0;
                        w_nxt_state = S_SHIFT;
                    end
                end
                S_ADD: begin
                    w_nxt_carry = alu_carry;
                    w_nxt_state = S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_last) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_cnt   = r_cnt + CNT_W'(1);
                        w_nxt_state = S_TEST;
                    end
                end
                S_DONE: begin
                    w_nxt_state = S_IDLE;
                end
                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_carry_q        <= 1'b0;
            acc_in_select    <= 1'b0;
            acc_high_select  <= SEL_IDLE;
            acc_low_select   <= SEL_IDLE;
            acc_high_reset_p <= 1'b0;
            fill_value       <= 1'b0;
            alu_add          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            r_state          <= w_nxt_state;
            r_cnt            <= w_nxt_cnt;
            r_carry_q        <= w_nxt_carry;
            acc_in_select    <= (w_nxt_state == S_LOAD_LO);
            acc_high_select  <= (w_nxt_state == S_ADD)     ? SEL_LOAD :
                                (w_nxt_state == S_SHIFT)   ? SEL_SHR  : SEL_IDLE;
            acc_low_select   <= (w_nxt_state == S_LOAD_LO) ? SEL_LOAD :
                                (w_nxt_state == S_SHIFT)   ? SEL_SHR  : SEL_IDLE;
            acc_high_reset_p <= (w_nxt_state == S_CLR_HI);
            fill_value       <= (w_nxt_state == S_SHIFT) && w_nxt_carry;
            alu_add          <= (w_nxt_state == S_ADD);
            busy             <= (w_nxt_state == S_LOAD_LO) || (w_nxt_state == S_CLR_HI) ||
                                (w_nxt_state == S_TEST)    || (w_nxt_state == S_ADD)    ||
                                (w_nxt_state == S_SHIFT);
            done             <= (w_nxt_state == S_DONE);
        end
    end

endmodule
